rx_dwidth_conv: RTL

- Receive-side gearbox: packs narrow lane words back into wide words, undoing the transmit-side wide-to-narrow serialiser.
- Sits between the lane receive datapath and the wide receive pipeline.
- The transmit serialiser sends the MSB slice first and marks it with a start-of-frame flag. This block uses that flag to lock and to check alignment.

---
 rtl/rx_dwidth_conv.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rx_dwidth_conv.sv
// ============================================================================
// Module   : rx_dwidth_conv
// Purpose  : Receive gearbox that packs SOF-aligned narrow lane words into wide words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_dwidth_conv #(
  parameter int DWIDTH_IN  = 64,
  parameter int DWIDTH_OUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DWIDTH_IN-1:0]  din,
  input  logic                  din_valid,
  input  logic                  sof_in,
  output logic [DWIDTH_OUT-1:0] dout,
  output logic                  dout_valid,
  output logic                  locked,
  output logic                  align_err,
  output logic [15:0]           err_cnt
);

  localparam int RATIO = DWIDTH_OUT / DWIDTH_IN;

  logic [DWIDTH_OUT-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  locked_q;
  logic                  align_err_q;
  logic [15:0]           err_cnt_q;

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;
  assign err_cnt    = err_cnt_q;

  generate
    if (RATIO == 1) begin : g_passthru
      // No framing to recover: every valid word is a complete wide word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          locked_q     <= 1'b0;
          align_err_q  <= 1'b0;
          err_cnt_q    <= '0;
        end else begin
          dout_valid_q <= din_valid;
          if (din_valid) dout_q <= din;
          locked_q     <= 1'b1;
          align_err_q  <= 1'b0;
          err_cnt_q    <= '0;
        end
      end
    end else begin : g_pack
      localparam int CW = $clog2(RATIO);

      typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
      } state_t;

      state_t                              state_q;
      logic [CW-1:0]                       cnt_q;
      logic [0:RATIO-2][DWIDTH_IN-1:0]     acc_q;
      logic [15:0]                         err_cnt_d;

      assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q      <= UNLOCKED;
          cnt_q        <= '0;
          acc_q        <= '0;
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          locked_q     <= 1'b0;
          align_err_q  <= 1'b0;
          err_cnt_q    <= '0;
        end else begin
          dout_valid_q <= 1'b0;
          align_err_q  <= 1'b0;
          if (din_valid) begin
            case (state_q)
              UNLOCKED: begin
                if (sof_in) begin
                  acc_q[0] <= din;
                  cnt_q    <= CW'(1);
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
              LOCKED: begin
                if (sof_in) begin
                  // An SOF mid-word abandons the partial word and resyncs on this one.
                  acc_q[0] <= din;
                  cnt_q    <= CW'(1);
                  if (cnt_q != '0) begin
                    align_err_q <= 1'b1;
                    err_cnt_q   <= err_cnt_d;
                  end
                end else if (cnt_q == '0) begin
                  align_err_q <= 1'b1;
                  err_cnt_q   <= err_cnt_d;
                  state_q     <= UNLOCKED;
                  locked_q    <= 1'b0;
                end else if (cnt_q == CW'(RATIO - 1)) begin
                  dout_q       <= {acc_q, din};
                  dout_valid_q <= 1'b1;
                  cnt_q        <= '0;
                end else begin
                  acc_q[cnt_q] <= din;
                  cnt_q        <= cnt_q + CW'(1);
                end
              end
              default: begin
                state_q  <= UNLOCKED;
                locked_q <= 1'b0;
                cnt_q    <= '0;
              end
            endcase
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
